// File: rtl/sgmii_lvds_align_ctrl.sv
// sgmii_lvds_align_ctrl: K28.5 word-alignment sequencer driving the LVDS Rx bit-slip input.
// Define SGMII_ALIGN_STATS_EN to add the loss-of-lock and slip statistics counters.
module sgmii_lvds_align_ctrl #(
    parameter int SLIP_PULSE_W = 2,
    parameter int SETTLE_CYC   = 16,
    parameter int HUNT_TIMEOUT = 1024,
    parameter int GOOD_COMMAS  = 4,
    parameter int ERR_WINDOW   = 64,
    parameter int ERR_THRESH   = 4
) (
    input  logic        i_Clk,
    input  logic        i_ARst_L,
    input  logic        i_RxReady,
    input  logic [7:0]  i8_RxCodeGroup,
    input  logic        i_RxCodeCtrl,
    input  logic        i_RxCodeInvalid,
    output logic        o_RxBitSlip,
    output logic        o_Aligned,
    output logic [3:0]  o4_SlipPos,
`ifdef SGMII_ALIGN_STATS_EN
    output logic [15:0] o16_LossCount,
    output logic [15:0] o16_SlipTotal,
`endif
    output logic        o_SlipBusy
);
    localparam int HT_W = $clog2(HUNT_TIMEOUT + 1);
    localparam int CC_W = $clog2(GOOD_COMMAS + 1);
    localparam int PH_W = $clog2((SLIP_PULSE_W > SETTLE_CYC ? SLIP_PULSE_W : SETTLE_CYC) + 1);
    localparam int WN_W = $clog2(ERR_WINDOW + 1);
    localparam int ER_W = $clog2(ERR_THRESH + 1);

    typedef enum logic [2:0] {S_WAIT, S_HUNT, S_CONFIRM, S_SLIP, S_SETTLE, S_LOCKED} state_t;

    state_t          r_State;
    logic            r_RxBitSlip, r_Aligned, r_SlipBusy;
    logic [3:0]      r_SlipPos;
    logic [HT_W-1:0] r_HuntTmr;
    logic [CC_W-1:0] r_CommaCnt;
    logic [PH_W-1:0] r_PhCnt;
    logic [WN_W-1:0] r_WinCnt;
    logic [ER_W-1:0] r_ErrCnt;
    logic [ER_W:0]   w_ErrSum;
    logic            w_Comma, w_HuntTo, w_Loss, w_SlipReq;

    assign w_Comma   = i_RxCodeCtrl && (i8_RxCodeGroup == 8'hBC) && !i_RxCodeInvalid;
    assign w_HuntTo  = r_HuntTmr == HT_W'(HUNT_TIMEOUT - 1);
    assign w_ErrSum  = {1'b0, r_ErrCnt} + {{ER_W{1'b0}}, i_RxCodeInvalid};
    assign w_Loss    = i_RxReady && (r_State == S_LOCKED) && (w_ErrSum >= (ER_W + 1)'(ERR_THRESH));
    // Errors and timeouts outrank a comma arriving in the same cycle.
    assign w_SlipReq = i_RxReady && (((r_State == S_HUNT) && w_HuntTo) ||
                                     ((r_State == S_CONFIRM) && (i_RxCodeInvalid || w_HuntTo)));

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_State     <= S_WAIT;
            r_RxBitSlip <= 1'b0;
            r_Aligned   <= 1'b0;
            r_SlipBusy  <= 1'b0;
            r_SlipPos   <= 4'd0;
            r_HuntTmr   <= '0;
            r_CommaCnt  <= '0;
            r_PhCnt     <= '0;
            r_WinCnt    <= '0;
            r_ErrCnt    <= '0;
        end else if (!i_RxReady) begin
            r_State     <= S_WAIT;
            r_RxBitSlip <= 1'b0;
            r_Aligned   <= 1'b0;
            r_SlipBusy  <= 1'b0;
            r_HuntTmr   <= '0;
            r_CommaCnt  <= '0;
            r_PhCnt     <= '0;
            r_WinCnt    <= '0;
            r_ErrCnt    <= '0;
        end else if (w_SlipReq) begin
            r_State     <= S_SLIP;
            r_RxBitSlip <= 1'b1;
            r_SlipBusy  <= 1'b1;
            r_SlipPos   <= (r_SlipPos == 4'd9) ? 4'd0 : r_SlipPos + 4'd1;
            r_PhCnt     <= '0;
            r_HuntTmr   <= '0;
            r_CommaCnt  <= '0;
        end else if (w_Loss) begin
            r_State   <= S_HUNT;
            r_Aligned <= 1'b0;
            r_HuntTmr <= '0;
            r_WinCnt  <= '0;
            r_ErrCnt  <= '0;
        end else begin
            case (r_State)
                S_WAIT: begin
                    r_State   <= S_HUNT;
                    r_HuntTmr <= '0;
                end
                S_HUNT: begin
                    if (w_Comma) begin
                        r_State    <= S_CONFIRM;
                        r_CommaCnt <= CC_W'(1);
                        r_HuntTmr  <= '0;
                    end else
                        r_HuntTmr <= r_HuntTmr + HT_W'(1);
                end
                S_CONFIRM: begin
                    if (w_Comma) begin
                        r_HuntTmr <= '0;
                        if (r_CommaCnt == CC_W'(GOOD_COMMAS - 1)) begin
                            r_State    <= S_LOCKED;
                            r_Aligned  <= 1'b1;
                            r_CommaCnt <= '0;
                            r_WinCnt   <= '0;
                            r_ErrCnt   <= '0;
                        end else
                            r_CommaCnt <= r_CommaCnt + CC_W'(1);
                    end else
                        r_HuntTmr <= r_HuntTmr + HT_W'(1);
                end
                S_SLIP: begin
                    if (r_PhCnt == PH_W'(SLIP_PULSE_W - 1)) begin
                        r_State     <= S_SETTLE;
                        r_RxBitSlip <= 1'b0;
                        r_PhCnt     <= '0;
                    end else
                        r_PhCnt <= r_PhCnt + PH_W'(1);
                end
                S_SETTLE: begin
                    if (r_PhCnt == PH_W'(SETTLE_CYC - 1)) begin
                        r_State    <= S_HUNT;
                        r_SlipBusy <= 1'b0;
                        r_PhCnt    <= '0;
                        r_HuntTmr  <= '0;
                    end else
                        r_PhCnt <= r_PhCnt + PH_W'(1);
                end
                S_LOCKED: begin
                    // The terminal cycle's error was already counted by the loss check.
                    if (r_WinCnt == WN_W'(ERR_WINDOW - 1)) begin
                        r_WinCnt <= '0;
                        r_ErrCnt <= '0;
                    end else begin
                        r_WinCnt <= r_WinCnt + WN_W'(1);
                        r_ErrCnt <= w_ErrSum[ER_W-1:0];
                    end
                end
                default: r_State <= S_WAIT;
            endcase
        end
    end

`ifdef SGMII_ALIGN_STATS_EN
    logic [15:0] r_LossCount, r_SlipTotal;

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_LossCount <= 16'd0;
            r_SlipTotal <= 16'd0;
        end else begin
            if (w_Loss && (r_LossCount != 16'hFFFF))
                r_LossCount <= r_LossCount + 16'd1;
            if (w_SlipReq && (r_SlipTotal != 16'hFFFF))
                r_SlipTotal <= r_SlipTotal + 16'd1;
        end
    end

    assign o16_LossCount = r_LossCount;
    assign o16_SlipTotal = r_SlipTotal;
`endif

    assign o_RxBitSlip = r_RxBitSlip;
    assign o_Aligned   = r_Aligned;
    assign o4_SlipPos  = r_SlipPos;
    assign o_SlipBusy  = r_SlipBusy;
endmodule

// File: tb/tb_sgmii_lvds_align_ctrl.sv
// tb_sgmii_lvds_align_ctrl: directed bench for the SGMII LVDS word-alignment sequencer.
module tb_sgmii_lvds_align_ctrl;
    logic        i_Clk = 1'b0;
    logic        i_ARst_L = 1'b0;
    logic        i_RxReady = 1'b0;
    logic [7:0]  i8_RxCodeGroup = 8'h50;
    logic        i_RxCodeCtrl = 1'b0;
    logic        i_RxCodeInvalid = 1'b0;
    logic        o_RxBitSlip, o_Aligned, o_SlipBusy;
    logic [3:0]  o4_SlipPos;
`ifdef SGMII_ALIGN_STATS_EN
    logic [15:0] o16_LossCount, o16_SlipTotal;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 i_Clk = ~i_Clk;

    sgmii_lvds_align_ctrl dut (
        .i_Clk          (i_Clk),
        .i_ARst_L       (i_ARst_L),
        .i_RxReady      (i_RxReady),
        .i8_RxCodeGroup (i8_RxCodeGroup),
        .i_RxCodeCtrl   (i_RxCodeCtrl),
        .i_RxCodeInvalid(i_RxCodeInvalid),
        .o_RxBitSlip    (o_RxBitSlip),
        .o_Aligned      (o_Aligned),
        .o4_SlipPos     (o4_SlipPos),
`ifdef SGMII_ALIGN_STATS_EN
        .o16_LossCount  (o16_LossCount),
        .o16_SlipTotal  (o16_SlipTotal),
`endif
        .o_SlipBusy     (o_SlipBusy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic [7:0] g, input logic v);
        i_RxCodeCtrl = c;
        i8_RxCodeGroup = g;
        i_RxCodeInvalid = v;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h50, 1'b0);
    endtask

    task automatic comma();
        cyc(1'b1, 8'hBC, 1'b0);
    endtask

    // Four commas spaced five code groups apart; lock must appear only after the fourth.
    task automatic lock_seq(input string tag);
        for (int k = 0; k < 4; k++) begin
            repeat (4) idle();
            comma();
            check($sformatf("%s_c%0d", tag, k), o_Aligned, (k == 3) ? 1 : 0);
        end
    endtask

    initial begin
        int   n, rises, t_prev;
        logic prev;
        #3;
        check("rst_slip", o_RxBitSlip, 0);
        check("rst_aligned", o_Aligned, 0);
        check("rst_busy", o_SlipBusy, 0);
        check("rst_pos", o4_SlipPos, 0);
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        i_RxReady = 1'b1;
        // Near-miss commas must not count
        cyc(1'b0, 8'hBC, 1'b0);
        cyc(1'b1, 8'hBC, 1'b1);
        cyc(1'b1, 8'h3C, 1'b0);
        lock_seq("clean_lock");
        check("clean_noslip", o_RxBitSlip, 0);
        check("clean_pos", o4_SlipPos, 0);

        for (int j = 0; j < 128; j++) begin
            cyc(1'b0, 8'h50, (j inside {10, 20, 30, 70, 80, 90, 127}) ? 1'b1 : 1'b0);
            if (j == 63 || j == 70 || j == 126)
                check($sformatf("win_keep%0d", j), o_Aligned, 1);
        end
        check("loss_aligned", o_Aligned, 0);
        check("loss_noslip", o_RxBitSlip, 0);
        check("loss_busy", o_SlipBusy, 0);
`ifdef SGMII_ALIGN_STATS_EN
        check("loss_count", o16_LossCount, 1);
`endif

        comma();
        repeat (4) idle();
        comma();
        idle();
        idle();
        cyc(1'b0, 8'h50, 1'b1);
        check("cf_slip1", o_RxBitSlip, 1);
        check("cf_busy", o_SlipBusy, 1);
        check("cf_pos", o4_SlipPos, 1);
        idle();
        check("cf_slip2", o_RxBitSlip, 1);
        idle();
        check("cf_slip_end", o_RxBitSlip, 0);
        check("cf_settle_busy", o_SlipBusy, 1);
        repeat (15) idle();
        check("settle_last", o_SlipBusy, 1);
        idle();
        check("settle_done", o_SlipBusy, 0);
        lock_seq("relock");

        i_ARst_L = 1'b0;
        #1;
        check("arst_aligned", o_Aligned, 0);
        check("arst_slip", o_RxBitSlip, 0);
        check("arst_busy", o_SlipBusy, 0);
        check("arst_pos", o4_SlipPos, 0);
        @(negedge i_Clk);
        i_ARst_L = 1'b1;

        n = 0;
        rises = 0;
        t_prev = 0;
        prev = 1'b0;
        while ((rises < 3 || o_SlipBusy) && n < 6000) begin
            idle();
            n++;
            if (o_RxBitSlip && !prev) begin
                rises++;
                if (rises == 1)
                    check("hunt_timeout", n, 1025);
                else
                    check($sformatf("slip_gap%0d", rises), n - t_prev, 1042);
                t_prev = n;
            end
            if (!o_RxBitSlip && prev)
                check($sformatf("slip_w%0d", rises), n - t_prev, 2);
            prev = o_RxBitSlip;
        end
        check("mis_slips", rises, 3);
        check("mis_pos", o4_SlipPos, 3);
        lock_seq("mis_lock");

        i_ARst_L = 1'b0;
        #1;
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        n = 0;
        rises = 0;
        prev = 1'b0;
        while (rises < 13 && n < 15000) begin
            idle();
            n++;
            if (o_RxBitSlip && !prev) begin
                rises++;
                if (rises <= 12)
                    check($sformatf("pos_seq%0d", rises), o4_SlipPos, rises % 10);
                if (rises == 12) begin
                    check("pos_end", o4_SlipPos, 2);
`ifdef SGMII_ALIGN_STATS_EN
                    check("slip_total", o16_SlipTotal, 12);
`endif
                end
            end
            prev = o_RxBitSlip;
        end
        check("slip13", rises, 13);
        check("slip13_high", o_RxBitSlip, 1);

        i_RxReady = 1'b0;
        idle();
        check("drop_slip", o_RxBitSlip, 0);
        check("drop_busy", o_SlipBusy, 0);
        check("drop_pos", o4_SlipPos, 3);
        i_RxReady = 1'b1;
        lock_seq("ready_relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
